// File: rtl/lidar_meas_ctrl.sv
// TF-LC02 LiDAR measurement sequencer.
// Sends the 5-byte read command through an external UART_TX and parses the
// 8-byte reply from UART_RX. It runs on request or periodically, with a reply
// timeout and bounded retry. Results are registered outputs with 1-cycle strobes.
module lidar_meas_ctrl #(
  parameter int unsigned PERIOD_CYC  = 5_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic        i_Auto,
  output logic        o_Tx_fTx,
  output logic [7:0]  o_Tx_Data,
  input  logic        i_Tx_fReady,
  input  logic        i_Tx_fDone,
  input  logic        i_Rx_fDone,
  input  logic [7:0]  i_Rx_Data,
  output logic [15:0] o_Distance,
  output logic [7:0]  o_SensStat,
  output logic        o_fValid,
  output logic        o_fError,
  output logic [1:0]  o_ErrCode,
  output logic        o_Busy,
  output logic [2:0]  o_State
);

  localparam int unsigned PerW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [PerW-1:0] PerLast  = PerW'(PERIOD_CYC - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      RetryMax = 3'(MAX_RETRY);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StTxByte = 3'd1;
  localparam logic [2:0] StTxWait = 3'd2;
  localparam logic [2:0] StRxFrame = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StFail   = 3'd5;

  localparam logic [1:0] ErrTimeout = 2'd0;
  localparam logic [1:0] ErrFooter  = 2'd1;
  localparam logic [1:0] ErrStatus  = 2'd2;

  logic [2:0]      state_q, state_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [2:0]      retry_q, retry_d;
  logic [PerW-1:0] per_cnt_q, per_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      b4_q, b4_d;
  logic [7:0]      b5_q, b5_d;
  logic [7:0]      b6_q, b6_d;
  logic [1:0]      fail_code_q, fail_code_d;
  logic [15:0]     distance_q, distance_d;
  logic [7:0]      sens_stat_q, sens_stat_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [7:0] cmd_byte;
  logic [7:0] hdr_byte;
  logic       tx_fire;
  logic       start_due;

  // Command byte selected by the transmit index
  always_comb begin
    cmd_byte = 8'h00;
    case (tx_idx_q)
      3'd0:    cmd_byte = 8'h55;
      3'd1:    cmd_byte = 8'hAA;
      3'd2:    cmd_byte = 8'h81;
      3'd3:    cmd_byte = 8'h00;
      3'd4:    cmd_byte = 8'hFA;
      default: cmd_byte = 8'h00;
    endcase
  end

  // Expected reply header byte at the current receive index (bytes 0..3)
  always_comb begin
    hdr_byte = 8'h00;
    case (rx_idx_q)
      3'd0:    hdr_byte = 8'h55;
      3'd1:    hdr_byte = 8'hAA;
      3'd2:    hdr_byte = 8'h81;
      3'd3:    hdr_byte = 8'h03;
      default: hdr_byte = 8'h00;
    endcase
  end

  assign tx_fire   = (state_q == StTxByte) && i_Tx_fReady;
  assign start_due = i_Auto && (per_cnt_q == PerLast);

  // Sequencer next-state, counters and result capture
  always_comb begin
    state_d     = state_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    retry_d     = retry_q;
    per_cnt_d   = per_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    b4_d        = b4_q;
    b5_d        = b5_q;
    b6_d        = b6_q;
    fail_code_d = fail_code_q;
    distance_d  = distance_q;
    sens_stat_d = sens_stat_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;

    // Period counter saturates at its last value so a trigger due while busy
    // fires as soon as the sequencer is back in idle.
    if (!i_Auto) begin
      per_cnt_d = '0;
    end else if (per_cnt_q != PerLast) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (i_Start || start_due) begin
          state_d   = StTxByte;
          tx_idx_d  = 3'd0;
          retry_d   = 3'd0;
          per_cnt_d = '0;
        end
      end

      StTxByte: begin
        if (i_Tx_fReady) begin
          state_d = StTxWait;
        end
      end

      StTxWait: begin
        if (i_Tx_fDone) begin
          if (tx_idx_q == 3'd4) begin
            state_d   = StRxFrame;
            tmo_cnt_d = '0;
            rx_idx_d  = 3'd0;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            state_d  = StTxByte;
          end
        end
      end

      StRxFrame: begin
        // Timeout wins over a byte arriving on the same cycle
        if (tmo_cnt_q == TmoLast) begin
          state_d     = StFail;
          fail_code_d = ErrTimeout;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (i_Rx_fDone) begin
            case (rx_idx_q)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                if (i_Rx_Data == hdr_byte) begin
                  rx_idx_d = rx_idx_q + 3'd1;
                end else begin
                  // Resync: a stray 55 may itself start the real header
                  rx_idx_d = (i_Rx_Data == 8'h55) ? 3'd1 : 3'd0;
                end
              end
              3'd4: begin
                b4_d     = i_Rx_Data;
                rx_idx_d = 3'd5;
              end
              3'd5: begin
                b5_d     = i_Rx_Data;
                rx_idx_d = 3'd6;
              end
              3'd6: begin
                b6_d     = i_Rx_Data;
                rx_idx_d = 3'd7;
              end
              default: begin
                if (i_Rx_Data == 8'hFA) begin
                  state_d = StDone;
                end else begin
                  state_d     = StFail;
                  fail_code_d = ErrFooter;
                end
              end
            endcase
          end
        end
      end

      StDone: begin
        sens_stat_d = b6_q;
        if (b6_q == 8'h00) begin
          distance_d = {b4_q, b5_q};
          valid_d    = 1'b1;
          state_d    = StIdle;
        end else begin
          fail_code_d = ErrStatus;
          state_d     = StFail;
        end
      end

      StFail: begin
        if (retry_q < RetryMax) begin
          retry_d  = retry_q + 3'd1;
          tx_idx_d = 3'd0;
          state_d  = StTxByte;
        end else begin
          error_d    = 1'b1;
          err_code_d = fail_code_q;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously on reset
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= StIdle;
      tx_idx_q    <= 3'd0;
      rx_idx_q    <= 3'd0;
      retry_q     <= 3'd0;
      per_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      b4_q        <= 8'h00;
      b5_q        <= 8'h00;
      b6_q        <= 8'h00;
      fail_code_q <= 2'd0;
      distance_q  <= 16'h0000;
      sens_stat_q <= 8'h00;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      tx_idx_q    <= tx_idx_d;
      rx_idx_q    <= rx_idx_d;
      retry_q     <= retry_d;
      per_cnt_q   <= per_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      b4_q        <= b4_d;
      b5_q        <= b5_d;
      b6_q        <= b6_d;
      fail_code_q <= fail_code_d;
      distance_q  <= distance_d;
      sens_stat_q <= sens_stat_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  // The TX strobe is combinational so it drops in the same cycle reset is asserted
  assign o_Tx_fTx   = tx_fire;
  assign o_Tx_Data  = tx_fire ? cmd_byte : 8'h00;
  assign o_Distance = distance_q;
  assign o_SensStat = sens_stat_q;
  assign o_fValid   = valid_q;
  assign o_fError   = error_q;
  assign o_ErrCode  = err_code_q;
  assign o_Busy     = (state_q != StIdle);
  assign o_State    = state_q;

endmodule

// File: tb/tb_lidar_meas_ctrl.sv
// Directed bench for lidar_meas_ctrl with a small UART_TX handshake model.
module tb_lidar_meas_ctrl;

  localparam int unsigned PER = 2000;
  localparam int unsigned TMO = 200;
  localparam int unsigned MR  = 3;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_Auto = 1'b0;
  logic        i_Tx_fReady = 1'b1;
  logic        i_Tx_fDone = 1'b0;
  logic        i_Rx_fDone = 1'b0;
  logic [7:0]  i_Rx_Data = 8'h00;
  logic        o_Tx_fTx;
  logic [7:0]  o_Tx_Data;
  logic [15:0] o_Distance;
  logic [7:0]  o_SensStat;
  logic        o_fValid;
  logic        o_fError;
  logic [1:0]  o_ErrCode;
  logic        o_Busy;
  logic [2:0]  o_State;

  int n_pass = 0;
  int n_chk = 0;
  int n_valid = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] tx_q[$];

  lidar_meas_ctrl #(
    .PERIOD_CYC (PER),
    .TIMEOUT_CYC(TMO),
    .MAX_RETRY  (MR)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_Auto     (i_Auto),
    .o_Tx_fTx   (o_Tx_fTx),
    .o_Tx_Data  (o_Tx_Data),
    .i_Tx_fReady(i_Tx_fReady),
    .i_Tx_fDone (i_Tx_fDone),
    .i_Rx_fDone (i_Rx_fDone),
    .i_Rx_Data  (i_Rx_Data),
    .o_Distance (o_Distance),
    .o_SensStat (o_SensStat),
    .o_fValid   (o_fValid),
    .o_fError   (o_fError),
    .o_ErrCode  (o_ErrCode),
    .o_Busy     (o_Busy),
    .o_State    (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Strobe counters sampled mid-cycle
  always @(negedge i_Clk) begin
    if (o_fValid) n_valid <= n_valid + 1;
    if (o_fError) n_err <= n_err + 1;
  end

  // UART_TX model: accept a byte, stay busy 3 cycles, then pulse done
  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_Tx_fTx) begin
        tx_q.push_back(o_Tx_Data);
        @(posedge i_Clk); #1;
        i_Tx_fReady = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1 i_Tx_fDone = 1'b1;
        @(posedge i_Clk); #1;
        i_Tx_fDone  = 1'b0;
        i_Tx_fReady = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_Clk); #1;
  endtask

  task automatic pulse_start();
    step();
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    i_Rx_fDone = 1'b1;
    i_Rx_Data  = b;
    step();
    i_Rx_fDone = 1'b0;
  endtask

  // Send the top n bytes of f, most significant first
  task automatic send_bytes(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[63-8*i -: 8]);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k = 0;
    while (o_State !== st && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(o_State), 32'(st));
  endtask

  task automatic wait_error(input int budget, input string tag);
    int k = 0;
    while (o_fError !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(o_fError), 32'd1);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int k = 0;
    while (o_Busy !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(o_Busy), 32'd1);
  endtask

  task automatic chk_cmd(input string tag, input int base);
    logic [39:0] cmd = 40'h55AA8100FA;
    chk({tag, "_txcnt"}, 32'(tx_q.size()), 32'(base + 5));
    for (int i = 0; i < 5; i++) begin
      if (tx_q.size() > base + i) chk({tag, "_txbyte"}, 32'(tx_q[base+i]), 32'(cmd[39-8*i -: 8]));
    end
  endtask

  initial begin
    int c0, c1, c2, v0, e0;

    // Reset values while reset held
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_state", 32'(o_State), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_dist", 32'(o_Distance), 32'd0);
    chk("rst_stat", 32'(o_SensStat), 32'd0);
    chk("rst_valid", 32'(o_fValid), 32'd0);
    chk("rst_error", 32'(o_fError), 32'd0);
    chk("rst_code", 32'(o_ErrCode), 32'd0);
    chk("rst_ftx", 32'(o_Tx_fTx), 32'd0);
    chk("rst_txdata", 32'(o_Tx_Data), 32'd0);
    i_Rst = 1'b1;
    repeat (2) step();

    // Basic measurement with exact result latency
    tx_q.delete();
    pulse_start();
    chk("t1_busy", 32'(o_Busy), 32'd1);
    wait_state(3'd3, 200, "t1_wait_rx");
    chk_cmd("t1", 0);
    send_bytes(64'h55AA8103015500FA, 7);
    send_byte(8'hFA);
    chk("t1_done_state", 32'(o_State), 32'd4);
    chk("t1_valid_early", 32'(o_fValid), 32'd0);
    step();
    chk("t1_valid", 32'(o_fValid), 32'd1);
    chk("t1_dist", 32'(o_Distance), 32'h0155);
    chk("t1_stat", 32'(o_SensStat), 32'h00);
    chk("t1_idle", 32'(o_State), 32'd0);
    step();
    chk("t1_valid_1cyc", 32'(o_fValid), 32'd0);
    chk("t1_nvalid", 32'(n_valid), 32'd1);
    chk("t1_nerr", 32'(n_err), 32'd0);

    // Junk ahead of the header must resync without error
    tx_q.delete();
    pulse_start();
    wait_state(3'd3, 200, "t2_wait_rx");
    send_byte(8'h12);
    send_byte(8'h55);
    send_bytes(64'h55AA8103006400FA, 8);
    repeat (2) step();
    chk("t2_dist", 32'(o_Distance), 32'd100);
    chk("t2_nvalid", 32'(n_valid), 32'd2);
    chk("t2_nerr", 32'(n_err), 32'd0);
    chk("t2_idle", 32'(o_State), 32'd0);

    // No reply: initial try plus three retries, then timeout error
    tx_q.delete();
    pulse_start();
    wait_error(4000, "t3_wait_err");
    chk("t3_code", 32'(o_ErrCode), 32'd0);
    chk("t3_txcnt", 32'(tx_q.size()), 32'd20);
    chk_cmd("t3_last", 15);
    chk("t3_dist", 32'(o_Distance), 32'd100);
    step();
    chk("t3_idle", 32'(o_State), 32'd0);
    chk("t3_nerr", 32'(n_err), 32'd1);

    // Bad footer, then a good reply on the retry
    tx_q.delete();
    v0 = n_valid;
    e0 = n_err;
    pulse_start();
    wait_state(3'd3, 200, "t4_wait_rx1");
    send_bytes(64'h55AA8103010000FB, 8);
    chk("t4_fail_state", 32'(o_State), 32'd5);
    wait_state(3'd3, 200, "t4_wait_rx2");
    chk("t4_txcnt", 32'(tx_q.size()), 32'd10);
    send_bytes(64'h55AA8103020000FA, 8);
    repeat (3) step();
    chk("t4_dist", 32'(o_Distance), 32'h0200);
    chk("t4_nvalid", 32'(n_valid), 32'(v0 + 1));
    chk("t4_nerr", 32'(n_err), 32'(e0));

    // Non-zero sensor status on every try
    tx_q.delete();
    v0 = n_valid;
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      wait_state(3'd3, 200, "t5_wait_rx");
      send_bytes(64'h55AA8103030002FA, 8);
    end
    wait_error(20, "t5_wait_err");
    chk("t5_code", 32'(o_ErrCode), 32'd2);
    chk("t5_stat", 32'(o_SensStat), 32'h02);
    chk("t5_dist", 32'(o_Distance), 32'h0200);
    chk("t5_txcnt", 32'(tx_q.size()), 32'd20);
    step();
    chk("t5_nvalid", 32'(n_valid), 32'(v0));

    // Periodic mode: starts spaced exactly PER cycles apart
    step();
    i_Auto = 1'b1;
    c0 = cyc;
    wait_busy(2500, "t6_start1");
    c1 = cyc;
    chk("t6_first_gap", 32'(c1 - c0), 32'(PER));
    wait_state(3'd3, 200, "t6_wait_rx1");
    send_bytes(64'h55AA8103030000FA, 8);
    step();
    chk("t6_dist", 32'(o_Distance), 32'h0300);
    step();
    chk("t6_idle", 32'(o_Busy), 32'd0);
    wait_busy(2500, "t6_start2");
    c2 = cyc;
    chk("t6_period", 32'(c2 - c1), 32'(PER));

    // Reset in the middle of a reply aborts everything
    wait_state(3'd3, 200, "t7_wait_rx");
    send_bytes(64'h55AA810000000000, 3);
    i_Auto = 1'b0;
    i_Rst  = 1'b0;
    #1;
    chk("t7_state", 32'(o_State), 32'd0);
    chk("t7_busy", 32'(o_Busy), 32'd0);
    chk("t7_dist", 32'(o_Distance), 32'd0);
    chk("t7_stat", 32'(o_SensStat), 32'd0);
    chk("t7_code", 32'(o_ErrCode), 32'd0);
    chk("t7_ftx", 32'(o_Tx_fTx), 32'd0);
    repeat (2) step();
    i_Rst = 1'b1;
    repeat (3) step();
    chk("t7_still_idle", 32'(o_State), 32'd0);

    // Clean run after reset
    tx_q.delete();
    v0 = n_valid;
    pulse_start();
    wait_state(3'd3, 200, "t8_wait_rx");
    chk_cmd("t8", 0);
    send_bytes(64'h55AA8103002A00FA, 8);
    step();
    chk("t8_valid", 32'(o_fValid), 32'd1);
    chk("t8_dist", 32'(o_Distance), 32'h002A);
    step();
    chk("t8_nvalid", 32'(n_valid), 32'(v0 + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
